// File: rtl/mult_issue_ctrl.sv
// Issue/sequencing controller for the multi-cycle booth multiplier in EX.
// Holds operands stable, freezes the pipeline while the product forms, then presents it for one cycle.
module mult_issue_ctrl #(
  parameter int unsigned MULT_LATENCY = 4,
  parameter logic [0:5]  OP_MULT      = 6'h0e,
  parameter logic [0:5]  OP_MULTU     = 6'h16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_valid_i,
  input  logic [0:5]  alu_ctrl_i,
  input  logic [0:31] opa_i,
  input  logic [0:31] opb_i,
  input  logic [0:4]  dest_reg_i,
  input  logic        flush_i,
  input  logic [0:63] product_i,
  output logic [0:31] mult_a_o,
  output logic [0:31] mult_b_o,
  output logic        mult_sign_o,
  output logic        reg_lock_o,
  output logic        busy_o,
  output logic [0:31] result_o,
  output logic        result_valid_o,
  output logic [0:4]  result_reg_o
);

  localparam int unsigned CNT_W = (MULT_LATENCY > 1) ? $clog2(MULT_LATENCY) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [0:31]      mult_a_q, mult_a_d;
  logic [0:31]      mult_b_q, mult_b_d;
  logic             sign_q, sign_d;
  logic [0:4]       dest_q, dest_d;
  logic [0:31]      result_q, result_d;
  logic [0:4]       result_reg_q, result_reg_d;

  logic is_mult;
  logic issue_fire;
  logic unused_product_hi;

  assign is_mult    = issue_valid_i && ((alu_ctrl_i == OP_MULT) || (alu_ctrl_i == OP_MULTU));
  assign issue_fire = (state_q == S_IDLE) && is_mult && !flush_i;

  // Only the low word of the product is forwarded to the pipeline.
  assign unused_product_hi = ^product_i[0:31];

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mult_a_d     = mult_a_q;
    mult_b_d     = mult_b_q;
    sign_d       = sign_q;
    dest_d       = dest_q;
    result_d     = result_q;
    result_reg_d = result_reg_q;
    case (state_q)
      S_IDLE: begin
        if (issue_fire) begin
          mult_a_d = opa_i;
          mult_b_d = opb_i;
          sign_d   = (alu_ctrl_i == OP_MULT);
          dest_d   = dest_reg_i;
          cnt_d    = CNT_W'(MULT_LATENCY - 1);
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        // A flush abandons the product; result keeps its previous value.
        if (flush_i) begin
          state_d = S_IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          result_d     = product_i[32:63];
          result_reg_d = dest_q;
          state_d      = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      mult_a_q     <= '0;
      mult_b_q     <= '0;
      sign_q       <= 1'b0;
      dest_q       <= '0;
      result_q     <= '0;
      result_reg_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mult_a_q     <= mult_a_d;
      mult_b_q     <= mult_b_d;
      sign_q       <= sign_d;
      dest_q       <= dest_d;
      result_q     <= result_d;
      result_reg_q <= result_reg_d;
    end
  end

  // Lock releases in DONE so the pipeline advances on the edge that captures result.
  assign reg_lock_o     = issue_fire || ((state_q == S_RUN) && !flush_i);
  assign busy_o         = (state_q == S_RUN);
  assign result_valid_o = (state_q == S_DONE) && !flush_i;
  assign mult_a_o       = mult_a_q;
  assign mult_b_o       = mult_b_q;
  assign mult_sign_o    = sign_q;
  assign result_o       = result_q;
  assign result_reg_o   = result_reg_q;

endmodule

// File: tb/tb_mult_issue_ctrl.sv
// Self-checking bench for mult_issue_ctrl: directed scenarios followed by randomized multiplies,
// each checked against a cycle timeline derived from issue time and plain 64-bit arithmetic.
module tb_mult_issue_ctrl;

  localparam int unsigned L        = 4;
  localparam logic [5:0]  OP_MULT  = 6'h0e;
  localparam logic [5:0]  OP_MULTU = 6'h16;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic [0:5]  alu_ctrl;
  logic [0:31] opa;
  logic [0:31] opb;
  logic [0:4]  dest_reg;
  logic        flush;
  logic [0:63] product;
  logic [0:31] mult_a;
  logic [0:31] mult_b;
  logic        mult_sign;
  logic        reg_lock;
  logic        busy;
  logic [0:31] result;
  logic        result_valid;
  logic [0:4]  result_reg;

  int total = 0;
  int bad   = 0;

  mult_issue_ctrl #(
    .MULT_LATENCY(L),
    .OP_MULT     (OP_MULT),
    .OP_MULTU    (OP_MULTU)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .issue_valid_i (issue_valid),
    .alu_ctrl_i    (alu_ctrl),
    .opa_i         (opa),
    .opb_i         (opb),
    .dest_reg_i    (dest_reg),
    .flush_i       (flush),
    .product_i     (product),
    .mult_a_o      (mult_a),
    .mult_b_o      (mult_b),
    .mult_sign_o   (mult_sign),
    .reg_lock_o    (reg_lock),
    .busy_o        (busy),
    .result_o      (result),
    .result_valid_o(result_valid),
    .result_reg_o  (result_reg)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] fullProduct(logic [31:0] a, logic [31:0] b, logic s);
    longint p;
    if (s) p = longint'($signed(a)) * longint'($signed(b));
    else   p = longint'({32'h0, a}) * longint'({32'h0, b});
    return 64'(p);
  endfunction

  // Stand-in for the booth multiplier: a pure function of the operands the controller presents.
  always_comb product = fullProduct(mult_a, mult_b, mult_sign);

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [5:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] d, input logic f);
    issue_valid = v;
    alu_ctrl    = op;
    opa         = a;
    opb         = b;
    dest_reg    = d;
    flush       = f;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkQuiet(input string tag);
    checkOutput({tag, "_lock"},  reg_lock,     0);
    checkOutput({tag, "_busy"},  busy,         0);
    checkOutput({tag, "_valid"}, result_valid, 0);
  endtask

  // Issue one multiply now and follow it cycle by cycle; fk selects a cycle to flush in (-1 = none).
  task automatic runMult(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic [4:0] d, input int fk);
    logic [31:0] exp;
    exp = fullProduct(a, b, s)[31:0];
    applyStimulus(1'b1, s ? OP_MULT : OP_MULTU, a, b, d, 1'b0);
    for (int k = 0; k <= int'(L) + 1; k++) begin
      if (k == fk) begin
        flush = 1'b1;
        #4;
        checkOutput("flush_lock",  reg_lock,     0);
        checkOutput("flush_valid", result_valid, 0);
        checkOutput("flush_busy",  busy,         64'(k >= 1 && k <= int'(L)));
        tick();
        applyStimulus(1'b0, 6'h00, 32'h0, 32'h0, 5'h0, 1'b0);
        repeat (L + 2) begin
          #4;
          checkQuiet("after_flush");
          tick();
        end
        return;
      end
      #4;
      if (k <= int'(L)) begin
        checkOutput("run_lock",  reg_lock,     1);
        checkOutput("run_busy",  busy,         64'(k >= 1));
        checkOutput("run_valid", result_valid, 0);
        if (k >= 1) begin
          checkOutput("mult_a",    mult_a,    a);
          checkOutput("mult_b",    mult_b,    b);
          checkOutput("mult_sign", mult_sign, s);
        end
      end else begin
        checkOutput("done_lock",   reg_lock,     0);
        checkOutput("done_busy",   busy,         0);
        checkOutput("done_valid",  result_valid, 1);
        checkOutput("result",      result,       exp);
        checkOutput("result_reg",  result_reg,   d);
      end
      tick();
    end
    applyStimulus(1'b0, 6'h00, 32'h0, 32'h0, 5'h0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] ra, rb;
    logic [5:0]  rop;
    int          fk;

    rst = 1'b1;
    applyStimulus(1'b0, 6'h00, 32'h0, 32'h0, 5'h0, 1'b0);
    #2;
    checkQuiet("reset");
    checkOutput("reset_mult_a", mult_a,     0);
    checkOutput("reset_result", result,     0);
    checkOutput("reset_rreg",   result_reg, 0);
    checkOutput("reset_sign",   mult_sign,  0);
    #1 rst = 1'b0;
    tick();

    $display("[TB] signed multiply -3 * 7");
    runMult(32'hFFFF_FFFD, 32'd7, 1'b1, 5'd5, -1);
    #4 checkQuiet("post_done");
    tick();

    $display("[TB] unsigned multiply FFFFFFFF * 2");
    runMult(32'hFFFF_FFFF, 32'd2, 1'b0, 5'd9, -1);

    $display("[TB] flush in second RUN cycle");
    runMult(32'd11, 32'd13, 1'b1, 5'd3, 2);

    $display("[TB] reset pulse mid-RUN");
    applyStimulus(1'b1, OP_MULT, 32'd100, 32'd200, 5'd7, 1'b0);
    tick();
    tick();
    #2;
    applyStimulus(1'b0, 6'h00, 32'h0, 32'h0, 5'h0, 1'b0);
    rst = 1'b1;
    #1;
    checkQuiet("async_reset");
    checkOutput("async_reset_a",    mult_a,    0);
    checkOutput("async_reset_b",    mult_b,    0);
    checkOutput("async_reset_sign", mult_sign, 0);
    #3 rst = 1'b0;
    tick();
    runMult(32'd9, 32'd9, 1'b0, 5'd1, -1);

    $display("[TB] non-multiply op");
    applyStimulus(1'b1, 6'h20, 32'd1, 32'd2, 5'd4, 1'b0);
    repeat (3) begin
      #4 checkQuiet("nonmult");
      tick();
    end
    applyStimulus(1'b0, 6'h00, 32'h0, 32'h0, 5'h0, 1'b0);
    tick();

    $display("[TB] back-to-back multiplies");
    runMult(32'd5, 32'd6, 1'b1, 5'd10, -1);
    runMult(32'd7, 32'd8, 1'b0, 5'd11, -1);

    $display("[TB] randomized multiplies");
    for (int i = 0; i < 16; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 4 == 1) rb = 32'($signed($urandom_range(0, 20)) - 10);
      fk = (i % 5 == 3) ? int'($urandom_range(0, L + 1)) : -1;
      runMult(ra, rb, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), fk);
      if ($urandom_range(0, 1) == 1) begin
        do rop = 6'($urandom_range(0, 63)); while (rop == OP_MULT || rop == OP_MULTU);
        applyStimulus(1'b1, rop, $urandom, $urandom, 5'($urandom_range(0, 31)), 1'b0);
        #4 checkQuiet("rand_nonmult");
        tick();
        applyStimulus(1'b0, 6'h00, 32'h0, 32'h0, 5'h0, 1'b0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
